// File: rtl/color_freq_if.sv
// Control and result bundle between the colortester register file (master) and the
// colour measurement core (slave).
interface color_freq_if #(
    parameter int CNT_W = 16
);
    logic             enable;
    logic             continuous;
    logic             start;
    logic             s2;
    logic             s3;
    logic [CNT_W-1:0] red_cnt;
    logic [CNT_W-1:0] green_cnt;
    logic [CNT_W-1:0] blue_cnt;
    logic [CNT_W-1:0] clear_cnt;
    logic [3:0]       sat;
    logic             busy;
    logic             data_valid;
    logic [7:0]       frame_cnt;
    logic [1:0]       color_id;

    modport master (
        output enable, continuous, start,
        input  s2, s3, red_cnt, green_cnt, blue_cnt, clear_cnt,
        input  sat, busy, data_valid, frame_cnt, color_id
    );

    modport slave (
        input  enable, continuous, start,
        output s2, s3, red_cnt, green_cnt, blue_cnt, clear_cnt,
        output sat, busy, data_valid, frame_cnt, color_id
    );
endinterface

// File: rtl/color_freq_sampler.sv
// TCS3200 measurement core: steps the filter selects through R,G,B,C and counts sensor edges per
// gate window. Define COLOR_CLASSIFY_EN to build the dominant-colour classifier on color_id.
//
// state  | meaning
// IDLE   | waiting for start (or continuous) with enable high
// SETTLE | selects already at the new channel, sensor output settling
// GATE   | counting synchronised sensor edges into the channel shadow
// DONE   | frame complete, shadow published on the exit edge
module color_freq_sampler #(
    parameter int GATE_CYCLES   = 100000,
    parameter int SETTLE_CYCLES = 1000,
    parameter int CNT_W         = 16
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        sensor_out,
    color_freq_if.slave bus
);
    localparam int MAX_CYC = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LD   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, SETTLE, GATE, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       ch;
    logic [1:0]       ch_nxt;
    logic [TMR_W-1:0] tmr;
    logic [TMR_W-1:0] tmr_nxt;
    logic             tc;
    logic [1:0]       sel_q;
    logic [2:0]       sync_q;
    logic             sens_edge;
    logic [CNT_W-1:0] cnt_sh [4];
    logic [3:0]       sat_sh;

    function automatic logic [1:0] ch_sel(input logic [1:0] c);
        case (c)
            2'd0:    ch_sel = 2'b00;
            2'd1:    ch_sel = 2'b11;
            2'd2:    ch_sel = 2'b01;
            default: ch_sel = 2'b10;
        endcase
    endfunction

    assign tc        = (tmr == '0);
    assign sens_edge = sync_q[1] & ~sync_q[2];
    assign bus.s2    = sel_q[1];
    assign bus.s3    = sel_q[0];
    assign bus.busy  = (state != IDLE);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], sensor_out};
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= IDLE;
            ch    <= '0;
            tmr   <= '0;
            sel_q <= 2'b00;
        end else begin
            state <= state_nxt;
            ch    <= ch_nxt;
            tmr   <= tmr_nxt;
            sel_q <= ch_sel(ch_nxt);
        end
    end

    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        tmr_nxt   = tc ? tmr : tmr - TMR_ONE;
        case (state)
            IDLE: begin
                if (bus.enable && (bus.start || bus.continuous)) begin
                    state_nxt = SETTLE;
                    ch_nxt    = 2'd0;
                    tmr_nxt   = SETTLE_LD;
                end
            end
            SETTLE: begin
                if (tc) begin
                    state_nxt = GATE;
                    tmr_nxt   = GATE_LD;
                end
            end
            GATE: begin
                if (tc) begin
                    if (ch == 2'd3) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = SETTLE;
                        ch_nxt    = ch + 2'd1;
                        tmr_nxt   = SETTLE_LD;
                    end
                end
            end
            DONE: begin
                ch_nxt = 2'd0;
                if (bus.continuous && bus.enable) begin
                    state_nxt = SETTLE;
                    tmr_nxt   = SETTLE_LD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Abort overrides everything; the stale shadow is never published.
        if (!bus.enable && state != IDLE) begin
            state_nxt = IDLE;
            ch_nxt    = 2'd0;
            tmr_nxt   = '0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < 4; i++) cnt_sh[i] <= '0;
            sat_sh <= '0;
        end else if (state == SETTLE && tc) begin
            cnt_sh[ch] <= '0;
            sat_sh[ch] <= 1'b0;
        end else if (state == GATE && sens_edge && cnt_sh[ch] != CNT_MAX) begin
            cnt_sh[ch] <= cnt_sh[ch] + CNT_ONE;
            if (cnt_sh[ch] == CNT_MAX - CNT_ONE) sat_sh[ch] <= 1'b1;
        end
    end

`ifdef COLOR_CLASSIFY_EN
    logic [1:0] color_nxt;

    // Ties keep the lower index; a dim clear channel overrides the colour decision.
    always_comb begin
        color_nxt = 2'd0;
        if (32'(cnt_sh[3]) < 32'd16) begin
            color_nxt = 2'd3;
        end else begin
            if (cnt_sh[1] > cnt_sh[0]) color_nxt = 2'd1;
            if (cnt_sh[2] > ((cnt_sh[1] > cnt_sh[0]) ? cnt_sh[1] : cnt_sh[0])) color_nxt = 2'd2;
        end
    end
`else
    assign bus.color_id = 2'b00;
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            bus.red_cnt    <= '0;
            bus.green_cnt  <= '0;
            bus.blue_cnt   <= '0;
            bus.clear_cnt  <= '0;
            bus.sat        <= '0;
            bus.frame_cnt  <= '0;
            bus.data_valid <= 1'b0;
`ifdef COLOR_CLASSIFY_EN
            bus.color_id   <= 2'd0;
`endif
        end else begin
            bus.data_valid <= 1'b0;
            if (state == DONE && bus.enable) begin
                bus.red_cnt    <= cnt_sh[0];
                bus.green_cnt  <= cnt_sh[1];
                bus.blue_cnt   <= cnt_sh[2];
                bus.clear_cnt  <= cnt_sh[3];
                bus.sat        <= sat_sh;
                bus.frame_cnt  <= bus.frame_cnt + 8'd1;
                bus.data_valid <= 1'b1;
`ifdef COLOR_CLASSIFY_EN
                bus.color_id   <= color_nxt;
`endif
            end
        end
    end
endmodule

// File: tb/tb_color_freq_sampler.sv
// Randomised bench for color_freq_sampler: logs the sensor pin per clock and derives every
// expected count, flag and frame timing from the measurement-window rules.
module tb_color_freq_sampler;
    localparam int GATE   = 100;
    localparam int SETTLE = 10;
    localparam int CW     = 5;
    localparam int CH     = SETTLE + GATE;
    localparam int FRAME  = 4 * CH;
    localparam int MAXV   = (1 << CW) - 1;
    localparam int LOGM   = 32767;

    logic ACLK       = 1'b0;
    logic ARESETN    = 1'b0;
    logic sensor_out = 1'b0;

    color_freq_if #(.CNT_W(CW)) bus ();

    color_freq_sampler #(
        .GATE_CYCLES  (GATE),
        .SETTLE_CYCLES(SETTLE),
        .CNT_W        (CW)
    ) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .sensor_out(sensor_out),
        .bus       (bus)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    bit plog [32768];

    // plog[n] holds the pin value seen at clock edge n
    always @(posedge ACLK) begin
        cyc <= cyc + 1;
        plog[(cyc + 1) & LOGM] <= sensor_out;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // 0: hold pin, 1: random half periods, 2: toggle every clock
    int sens_mode = 0;

    initial begin
        int hold;
        hold = 0;
        forever begin
            @(negedge ACLK);
            if (sens_mode == 2) begin
                sensor_out = ~sensor_out;
            end else if (sens_mode == 1) begin
                if (hold == 0) begin
                    sensor_out = ~sensor_out;
                    hold = $urandom_range(0, 6);
                end else begin
                    hold--;
                end
            end
        end
    end

    logic [1:0] sel_tab [4] = '{2'b00, 2'b11, 2'b01, 2'b10};
    int fc_model = 0;
    int last_cnt [4] = '{0, 0, 0, 0};
    int last_sat = 0;
    int last_col = 0;

    // Rising pin edges reach the counter three edges later; channel c counts over edges
    // k + c*CH + SETTLE + 1 .. k + c*CH + SETTLE + GATE, k being the edge that accepted the frame.
    function automatic int edges_in(input int k, input int chn);
        int c;
        int n0;
        c  = 0;
        n0 = k + chn * CH + SETTLE + 1;
        for (int n = n0; n < n0 + GATE; n++)
            if (plog[(n - 2) & LOGM] && !plog[(n - 3) & LOGM]) c++;
        return c;
    endfunction

    task automatic check_zero(input string pfx);
        check({pfx, "_red"},   32'(bus.red_cnt),    0);
        check({pfx, "_green"}, 32'(bus.green_cnt),  0);
        check({pfx, "_blue"},  32'(bus.blue_cnt),   0);
        check({pfx, "_clear"}, 32'(bus.clear_cnt),  0);
        check({pfx, "_sat"},   32'(bus.sat),        0);
        check({pfx, "_fcnt"},  32'(bus.frame_cnt),  0);
        check({pfx, "_busy"},  32'(bus.busy),       0);
        check({pfx, "_dv"},    32'(bus.data_valid), 0);
        check({pfx, "_sel"},   32'({bus.s2, bus.s3}), 0);
        check({pfx, "_color"}, 32'(bus.color_id),   0);
    endtask

    task automatic check_hold(input string pfx);
        check({pfx, "_red"},   32'(bus.red_cnt),   32'(last_cnt[0]));
        check({pfx, "_green"}, 32'(bus.green_cnt), 32'(last_cnt[1]));
        check({pfx, "_blue"},  32'(bus.blue_cnt),  32'(last_cnt[2]));
        check({pfx, "_clear"}, 32'(bus.clear_cnt), 32'(last_cnt[3]));
        check({pfx, "_sat"},   32'(bus.sat),       32'(last_sat));
        check({pfx, "_fcnt"},  32'(bus.frame_cnt), 32'(fc_model));
        check({pfx, "_color"}, 32'(bus.color_id),  32'(last_col));
    endtask

    // Follows one frame accepted at edge k until its data_valid (or a bounded timeout).
    task automatic track_frame(input int k, input bit poke, input int drop_cont, input bit busy_after);
        int dv_at;
        int e;
        int exp_cnt [4];
        int exp_sat;
        int exp_col;
        dv_at   = -1;
        exp_sat = 0;
        exp_col = 0;
        while (dv_at < 0 && cyc < k + FRAME + 4) begin
            @(negedge ACLK);
            bus.start = poke && (cyc == k + 2 * CH + 5);
            if (drop_cont >= 0 && cyc == k + drop_cont) bus.continuous = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (cyc == k + i * CH + SETTLE + GATE / 2) begin
                    check("sel", 32'({bus.s2, bus.s3}), 32'(sel_tab[i]));
                    check("busy", 32'(bus.busy), 1);
                end
            end
            if (bus.data_valid) dv_at = cyc;
        end
        bus.start = 1'b0;
        check("dv_cycle", 32'(dv_at), 32'(k + FRAME + 1));
        fc_model = (fc_model + 1) % 256;
        for (int i = 0; i < 4; i++) begin
            e = edges_in(k, i);
            exp_cnt[i] = (e > MAXV) ? MAXV : e;
            if (e >= MAXV) exp_sat = exp_sat | (1 << i);
        end
`ifdef COLOR_CLASSIFY_EN
        if (exp_cnt[3] < 16) begin
            exp_col = 3;
        end else begin
            if (exp_cnt[1] > exp_cnt[exp_col]) exp_col = 1;
            if (exp_cnt[2] > exp_cnt[exp_col]) exp_col = 2;
        end
`endif
        if (dv_at >= 0) begin
            check("red",       32'(bus.red_cnt),   32'(exp_cnt[0]));
            check("green",     32'(bus.green_cnt), 32'(exp_cnt[1]));
            check("blue",      32'(bus.blue_cnt),  32'(exp_cnt[2]));
            check("clear",     32'(bus.clear_cnt), 32'(exp_cnt[3]));
            check("sat",       32'(bus.sat),       32'(exp_sat));
            check("frame_cnt", 32'(bus.frame_cnt), 32'(fc_model));
            check("color",     32'(bus.color_id),  32'(exp_col));
            check("busy_post", 32'(bus.busy),      32'(busy_after));
            @(negedge ACLK);
            check("dv_pulse",  32'(bus.data_valid), 0);
        end
        last_cnt = exp_cnt;
        last_sat = exp_sat;
        last_col = exp_col;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int dv_seen;
        bus.enable     = 1'b0;
        bus.continuous = 1'b0;
        bus.start      = 1'b0;
        repeat (3) @(negedge ACLK);
        check_zero("reset");
        ARESETN   = 1'b1;
        sens_mode = 1;

        @(negedge ACLK);
        bus.start = 1'b1;
        @(negedge ACLK);
        bus.start = 1'b0;
        repeat (5) @(negedge ACLK);
        check("start_disabled", 32'(bus.busy), 0);

        bus.enable = 1'b1;
        for (int f = 0; f < 6; f++) begin
            sens_mode = (f == 2) ? 2 : ((f == 4) ? 0 : 1);
            repeat ($urandom_range(3, 20)) @(negedge ACLK);
            bus.start = 1'b1;
            k = cyc + 1;
            track_frame(k, f == 1, -1, 1'b0);
        end

        sens_mode = 1;
        @(negedge ACLK);
        bus.continuous = 1'b1;
        k = cyc + 1;
        track_frame(k, 1'b1, -1, 1'b1);
        k = k + FRAME + 1;
        track_frame(k, 1'b0, -1, 1'b1);
        k = k + FRAME + 1;
        track_frame(k, 1'b0, 200, 1'b0);
        repeat (3) @(negedge ACLK);
        check("idle_after_cont", 32'(bus.busy), 0);

        // enable dropped during the blue gate
        @(negedge ACLK);
        bus.start = 1'b1;
        k = cyc + 1;
        @(negedge ACLK);
        bus.start = 1'b0;
        while (cyc < k + 2 * CH + SETTLE + 30) @(negedge ACLK);
        bus.enable = 1'b0;
        @(negedge ACLK);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_sel",  32'({bus.s2, bus.s3}), 0);
        check("abort_dv",   32'(bus.data_valid), 0);
        check_hold("abort_hold");
        dv_seen = 0;
        repeat (FRAME + 20) begin
            @(negedge ACLK);
            if (bus.data_valid) dv_seen++;
        end
        check("abort_no_dv", 32'(dv_seen), 0);
        bus.enable = 1'b1;
        @(negedge ACLK);
        bus.start = 1'b1;
        k = cyc + 1;
        track_frame(k, 1'b0, -1, 1'b0);

        // reset asserted mid-settle
        @(negedge ACLK);
        bus.start = 1'b1;
        k = cyc + 1;
        @(negedge ACLK);
        bus.start = 1'b0;
        while (cyc < k + 5) @(negedge ACLK);
        check("pre_rst_busy", 32'(bus.busy), 1);
        ARESETN = 1'b0;
        #1;
        check_zero("midrst");
        fc_model = 0;
        @(negedge ACLK);
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        bus.start = 1'b1;
        k = cyc + 1;
        track_frame(k, 1'b0, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
